// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide sequencer for the RISC-V M extension.
// Runs shift-add multiply or restoring divide over XLEN cycles and applies RISC-V sign/corner rules.
module mdu_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [XLEN-1:0] negate_x(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*XLEN-1:0] negate_2x(input logic [2*XLEN-1:0] v);
        return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
    endfunction

    state_t              state_r, state_nxt_s;
    logic [2:0]          funct3_r;
    logic [XLEN-1:0]     opb_r;
    logic [2*XLEN-1:0]   acc_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                neg_a_r, neg_b_r, div_zero_r;
    logic [XLEN-1:0]     result_r;

    logic                accept_s, last_s;
    logic                sgn_a_s, sgn_b_s, neg_a_s, neg_b_s;
    logic [XLEN-1:0]     mag_a_s, mag_b_s;
    logic [2*XLEN-1:0]   acc_init_s, acc_nxt_s, prod_s;
    logic [XLEN-1:0]     opb_init_s, div_diff_s, quot_s, rem_s, res_s;
    logic [XLEN:0]       mul_sum_s, rem_sh_s;
    logic                div_ge_s;

    assign accept_s = (state_r == IDLE) && start && !flush;
    assign last_s   = (cnt_r == CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; flush wins from any state
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_nxt_s = start ? CALC : IDLE;
                CALC:    state_nxt_s = last_s ? DONE : CALC;
                DONE:    state_nxt_s = IDLE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Control outputs decoded from state
    always_comb begin
        busy  = (state_r != IDLE);
        done  = (state_r == DONE);
        stall = accept_s || (state_r == CALC);
    end

    // Operand capture: signed-ness per opcode, magnitudes and initial accumulator
    always_comb begin
        sgn_a_s = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
        sgn_b_s = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        neg_a_s = sgn_a_s && rs1[XLEN-1];
        neg_b_s = sgn_b_s && rs2[XLEN-1];
        mag_a_s = neg_a_s ? negate_x(rs1) : rs1;
        mag_b_s = neg_b_s ? negate_x(rs2) : rs2;
        if (funct3[2]) begin
            acc_init_s = {{XLEN{1'b0}}, mag_a_s};
            opb_init_s = mag_b_s;
        end else begin
            acc_init_s = {{XLEN{1'b0}}, mag_b_s};
            opb_init_s = mag_a_s;
        end
    end

    // One iteration: shift-add multiply or restoring divide step
    always_comb begin
        acc_nxt_s  = acc_r;
        mul_sum_s  = {(XLEN+1){1'b0}};
        rem_sh_s   = {(XLEN+1){1'b0}};
        div_diff_s = {XLEN{1'b0}};
        div_ge_s   = 1'b0;
        if (funct3_r[2]) begin
            // Shifted remainder can reach XLEN+1 bits; the difference always fits XLEN
            rem_sh_s   = acc_r[2*XLEN-1:XLEN-1];
            div_ge_s   = (rem_sh_s >= {1'b0, opb_r});
            div_diff_s = rem_sh_s[XLEN-1:0] - opb_r;
            if (div_ge_s) begin
                acc_nxt_s = {div_diff_s, acc_r[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt_s = {rem_sh_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
            end
        end else begin
            if (acc_r[0]) begin
                mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, opb_r};
            end else begin
                mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]};
            end
            acc_nxt_s = {mul_sum_s, acc_r[XLEN-1:1]};
        end
    end

    // Final result selection with sign fix and divide-by-zero override
    always_comb begin
        prod_s = (neg_a_r ^ neg_b_r) ? negate_2x(acc_nxt_s) : acc_nxt_s;
        quot_s = acc_nxt_s[XLEN-1:0];
        rem_s  = acc_nxt_s[2*XLEN-1:XLEN];
        case (funct3_r)
            3'b000:                 res_s = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: res_s = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         res_s = div_zero_r ? {XLEN{1'b1}} :
                                            ((neg_a_r ^ neg_b_r) ? negate_x(quot_s) : quot_s);
            3'b110, 3'b111:         res_s = neg_a_r ? negate_x(rem_s) : rem_s;
            default:                res_s = {XLEN{1'b0}};
        endcase
    end

    // Datapath registers: capture in IDLE, iterate in CALC, load result on the last step
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            funct3_r   <= 3'b000;
            opb_r      <= {XLEN{1'b0}};
            acc_r      <= {(2*XLEN){1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            neg_a_r    <= 1'b0;
            neg_b_r    <= 1'b0;
            div_zero_r <= 1'b0;
            result_r   <= {XLEN{1'b0}};
        end else if (accept_s) begin
            funct3_r   <= funct3;
            opb_r      <= opb_init_s;
            acc_r      <= acc_init_s;
            cnt_r      <= {CNT_W{1'b0}};
            neg_a_r    <= neg_a_s;
            neg_b_r    <= neg_b_s;
            div_zero_r <= funct3[2] && (rs2 == {XLEN{1'b0}});
        end else if ((state_r == CALC) && !flush) begin
            acc_r <= acc_nxt_s;
            cnt_r <= cnt_r + CNT_ONE;
            if (last_s) begin
                result_r <= res_s;
            end
        end
    end

    assign result = result_r;

endmodule
